// File: rtl/lut_cfg_writer_pkg.sv
// Shared FSM encoding and sizing helper for the LUTRAM configuration loader.
// The readback option is LUT_CFG_READBACK_EN; the encodings below serve both builds.
package lut_cfg_writer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // One extra bit so the terminal count is an explicit compare, never a wrap.
  function automatic int unsigned cnt_width(input int unsigned k);
    return k + 1;
  endfunction

endpackage

// File: rtl/lut_cfg_we_dec.sv
// LUT index to one-hot write-enable decoder with range-error flag; purely combinational.
// Used by lut_cfg_writer in every build, including LUT_CFG_READBACK_EN.
module lut_cfg_we_dec
  import lut_cfg_writer_pkg::*;
#(
  parameter int unsigned NUM_LUTS = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic [IDX_W-1:0]    i_idx,
  input  logic                i_en,
  output logic [NUM_LUTS-1:0] o_we_c,
  output logic                o_range_err_c
);

  always_comb begin
    o_we_c        = '0;
    o_range_err_c = i_en && (32'(i_idx) >= NUM_LUTS);
    for (int unsigned i = 0; i < NUM_LUTS; i++) begin
      o_we_c[i] = i_en && (32'(i_idx) == i);
    end
  end

endmodule

// File: rtl/lut_cfg_writer.sv
// Serialises one LUT mask per handshake onto the shared LUTRAM write port.
// Define LUT_CFG_READBACK_EN to add a VERIFY pass that reads each bit back and flags mismatches.
module lut_cfg_writer
  import lut_cfg_writer_pkg::*;
#(
  parameter int unsigned K        = 6,
  parameter int unsigned NUM_LUTS = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [IDX_W-1:0]    cfg_lut_idx,
  input  logic [(1<<K)-1:0]   cfg_mask,
  output logic [K-1:0]        lut_a,
  output logic                lut_d,
  output logic [NUM_LUTS-1:0] lut_we,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
`ifdef LUT_CFG_READBACK_EN
  ,
  output logic [K-1:0]        rb_a,
  output logic [IDX_W-1:0]    rb_sel,
  input  logic                rb_dpo,
  output logic                cfg_mismatch
`endif
);

  localparam int unsigned DEPTH = 1 << K;
  localparam int unsigned CNT_W = cnt_width(K);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DEPTH-1:0]    r_mask;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [NUM_LUTS-1:0] w_we;
  logic                w_range_err;
  logic                w_xfer;
`ifdef LUT_CFG_READBACK_EN
  logic [IDX_W-1:0]    r_idx;
  logic                r_in_range;
`endif

  assign cfg_ready = (r_state == ST_IDLE) && !rst;
  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  lut_cfg_we_dec #(
    .NUM_LUTS (NUM_LUTS),
    .IDX_W    (IDX_W)
  ) u_we_dec (
    .i_idx         (cfg_lut_idx),
    .i_en          (r_state == ST_IDLE),
    .o_we_c        (w_we),
    .o_range_err_c (w_range_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      lut_a   <= '0;
      lut_d   <= 1'b0;
      lut_we  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
`ifdef LUT_CFG_READBACK_EN
      rb_a         <= '0;
      rb_sel       <= '0;
      cfg_mismatch <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_state <= ST_WRITE;
            r_mask  <= cfg_mask;
            r_cnt   <= '0;
            lut_a   <= '0;
            lut_d   <= cfg_mask[0];
            lut_we  <= w_we;
            busy    <= 1'b1;
            if (w_range_err) cfg_err <= 1'b1;
`ifdef LUT_CFG_READBACK_EN
            r_idx      <= cfg_lut_idx;
            r_in_range <= !w_range_err;
`endif
          end
        end
        ST_WRITE: begin
          if (r_cnt == LAST) begin
            lut_we <= '0;
            lut_a  <= '0;
            lut_d  <= 1'b0;
            r_cnt  <= '0;
`ifdef LUT_CFG_READBACK_EN
            // Nothing was written for an out-of-range index, so there is nothing to verify.
            if (r_in_range) begin
              r_state <= ST_VERIFY;
              rb_a    <= '0;
              rb_sel  <= r_idx;
            end else begin
              r_state <= ST_FINISH;
              done    <= 1'b1;
            end
`else
            r_state <= ST_FINISH;
            done    <= 1'b1;
`endif
          end else begin
            r_cnt <= w_cnt_nxt;
            lut_a <= w_cnt_nxt[K-1:0];
            lut_d <= r_mask[w_cnt_nxt[K-1:0]];
          end
        end
`ifdef LUT_CFG_READBACK_EN
        ST_VERIFY: begin
          if (rb_dpo != r_mask[r_cnt[K-1:0]]) cfg_mismatch <= 1'b1;
          if (r_cnt == LAST) begin
            r_state <= ST_FINISH;
            done    <= 1'b1;
            rb_a    <= '0;
          end else begin
            r_cnt <= w_cnt_nxt;
            rb_a  <= w_cnt_nxt[K-1:0];
          end
        end
`endif
        ST_FINISH: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          lut_we  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_cfg_writer.sv
// Scoreboard bench for lut_cfg_writer (16-LUT instance plus a 12-LUT instance for range errors).
// Build with LUT_CFG_READBACK_EN to add a behavioural LUTRAM and the VERIFY checks.
module tb_lut_cfg_writer;

`ifdef LUT_CFG_READBACK_EN
  localparam int unsigned GAP = 130;
`else
  localparam int unsigned GAP = 66;
`endif

  typedef struct packed {
    logic [15:0] we;
    logic [63:0] mask;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_lut_idx;
  logic [63:0] cfg_mask;
  logic [5:0]  lut_a;
  logic        lut_d;
  logic [15:0] lut_we;
  logic        busy, done, cfg_err;

  logic        v12, rdy12, d12, busy12, done12, err12;
  logic [3:0]  idx12;
  logic [63:0] mask12;
  logic [5:0]  a12;
  logic [11:0] we12;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned n_acc   = 0;
  int unsigned n_done16 = 0;
  int unsigned cyc     = 0;
  bit          sb_busy = 0;
  exp_t        sb_q[$];
  int unsigned acc_q[$];

`ifdef LUT_CFG_READBACK_EN
  logic [5:0]  rb_a, rb_a12;
  logic [3:0]  rb_sel, rb_sel12;
  logic        rb_dpo, cfg_mismatch, mm12;
  logic [63:0] lram [16];
  bit          rb_stuck = 0;

  always @(posedge clk)
    for (int i = 0; i < 16; i++)
      if (lut_we[i]) lram[i][lut_a] <= lut_d;

  assign rb_dpo = (rb_stuck && rb_a == 6'd5) ? 1'b0 : lram[rb_sel][rb_a];
`endif

  lut_cfg_writer #(.K(6), .NUM_LUTS(16), .IDX_W(4)) u_dut (
    .clk (clk), .rst (rst), .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
    .cfg_lut_idx (cfg_lut_idx), .cfg_mask (cfg_mask), .lut_a (lut_a), .lut_d (lut_d),
    .lut_we (lut_we), .busy (busy), .done (done), .cfg_err (cfg_err)
`ifdef LUT_CFG_READBACK_EN
    , .rb_a (rb_a), .rb_sel (rb_sel), .rb_dpo (rb_dpo), .cfg_mismatch (cfg_mismatch)
`endif
  );

  lut_cfg_writer #(.K(6), .NUM_LUTS(12), .IDX_W(4)) u_dut12 (
    .clk (clk), .rst (rst), .cfg_valid (v12), .cfg_ready (rdy12),
    .cfg_lut_idx (idx12), .cfg_mask (mask12), .lut_a (a12), .lut_d (d12),
    .lut_we (we12), .busy (busy12), .done (done12), .cfg_err (err12)
`ifdef LUT_CFG_READBACK_EN
    , .rb_a (rb_a12), .rb_sel (rb_sel12), .rb_dpo (1'b0), .cfg_mismatch (mm12)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int unsigned n);
    int unsigned t;
    t = 0;
    while (n_acc < n && t < 400) begin
      tick();
      t++;
    end
    if (n_acc < n) chk("acc_timeout", 128'(n_acc), 128'(n));
  endtask

  function automatic logic [15:0] exp_onehot(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  // Push the expected write burst for every accepted handshake.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (cfg_valid && cfg_ready) begin
        e.we   = exp_onehot(cfg_lut_idx);
        e.mask = cfg_mask;
        sb_q.push_back(e);
        acc_q.push_back(cyc);
        n_acc++;
      end
    end
  end

  always @(negedge clk) if (done) n_done16++;

  // Pop one expected burst and compare the 2**K write cycles plus the done cycle.
  initial begin
    exp_t cur;
    int unsigned we_bad, a_bad, d_bad;
    bit aborted;
    forever begin
      while (sb_q.size() == 0) tick();
      cur = sb_q.pop_front();
      sb_busy = 1;
      aborted = 0;
      we_bad = 0; a_bad = 0; d_bad = 0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (rst) begin
          aborted = 1;
          break;
        end
        if (lut_we !== cur.we)      we_bad++;
        if (lut_a !== 6'(i))        a_bad++;
        if (lut_d !== cur.mask[i])  d_bad++;
      end
      if (!aborted) begin
`ifdef LUT_CFG_READBACK_EN
        repeat (64) @(negedge clk);
`endif
        @(negedge clk);
        chk("we_run", 128'(we_bad), 128'(0));
        chk("addr_seq", 128'(a_bad), 128'(0));
        chk("data_seq", 128'(d_bad), 128'(0));
        chk("done_we_off", {done, lut_we}, {1'b1, 16'h0000});
      end
      sb_busy = 0;
    end
  end

  initial begin
    int unsigned nz, dn, d0, t;
    rst = 1'b1; cfg_valid = 1'b0; cfg_lut_idx = '0; cfg_mask = '0;
    v12 = 1'b0; idx12 = '0; mask12 = '0;
    repeat (3) tick();
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_outs", {lut_a, lut_d, lut_we, busy, done, cfg_err}, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", {cfg_ready, busy, done, cfg_err, lut_we, lut_a, lut_d}, {1'b1, 26'd0});
    end

    // Single load, then a held valid measures the acceptance spacing.
    tick();
    cfg_valid = 1'b1; cfg_lut_idx = 4'd3; cfg_mask = 64'h8000_0000_0000_0001;
    wait_acc(1);
    cfg_lut_idx = 4'd5; cfg_mask = 64'hA5A5_0F0F_1234_5678;
    wait_acc(2);
    cfg_valid = 1'b0;
    chk("gap_first", 128'(acc_q[1] - acc_q[0]), 128'(GAP));

    // Back-to-back with valid held: idx 0 then idx 15.
    cfg_valid = 1'b1; cfg_lut_idx = 4'd0; cfg_mask = '1;
    wait_acc(3);
    cfg_lut_idx = 4'd15;
    wait_acc(4);
    cfg_valid = 1'b0;
    chk("gap_b2b", 128'(acc_q[3] - acc_q[2]), 128'(GAP));
    t = 0;
    while ((sb_q.size() != 0 || sb_busy || busy) && t < 400) begin tick(); t++; end
    chk("drain1", {sb_busy, busy}, 2'b00);
    chk("n_acc", 128'(n_acc), 128'(4));
    chk("n_done", 128'(n_done16), 128'(4));

    // Reset pulse in the middle of a write burst.
    cfg_valid = 1'b1; cfg_lut_idx = 4'd7; cfg_mask = 64'hDEAD_BEEF_0123_4567;
    wait_acc(5);
    cfg_valid = 1'b0;
    t = 0;
    while (!(lut_a == 6'd20 && lut_we != 0) && t < 100) begin tick(); t++; end
    chk("reach_cnt20", {lut_a, lut_we}, {6'd20, 16'h0080});
    rst = 1'b1;
    d0 = n_done16;
    tick();
    chk("rst_we_off", {lut_we, busy, done}, 18'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_back", cfg_ready, 1'b1);
    repeat (80) tick();
    chk("rst_no_done", 128'(n_done16 - d0), 128'(0));

    // Out-of-range index on the 12-LUT instance.
    tick();
    v12 = 1'b1; idx12 = 4'd13; mask12 = '1;
    tick();
    v12 = 1'b0;
    chk("oor_err_set", {err12, busy12}, 2'b11);
    nz = 0; dn = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (we12 != 0) nz++;
      if (done12) dn++;
    end
    chk("oor_we_zero", 128'(nz), 128'(0));
    chk("oor_done", 128'(dn), 128'(1));
    tick();
    v12 = 1'b1; idx12 = 4'd11; mask12 = 64'h0F;
    tick();
    v12 = 1'b0;
    chk("we12_idx11", we12, 12'h800);
    chk("oor_err_sticky", err12, 1'b1);
    repeat (140) tick();
    chk("oor_err_hold", {err12, busy12}, 2'b10);

`ifdef LUT_CFG_READBACK_EN
    chk("rb_clean", cfg_mismatch, 1'b0);
    cfg_valid = 1'b1; cfg_lut_idx = 4'd2; cfg_mask = '1;
    wait_acc(6);
    cfg_valid = 1'b0;
    t = 0;
    while ((sb_q.size() != 0 || sb_busy || busy) && t < 400) begin tick(); t++; end
    chk("rb_clean_after", cfg_mismatch, 1'b0);
    rb_stuck = 1;
    cfg_valid = 1'b1; cfg_lut_idx = 4'd4; cfg_mask = '1;
    wait_acc(7);
    cfg_valid = 1'b0;
    t = 0;
    while ((sb_q.size() != 0 || sb_busy || busy) && t < 400) begin tick(); t++; end
    chk("rb_stuck_mm", cfg_mismatch, 1'b1);
`endif

    t = 0;
    while ((sb_q.size() != 0 || sb_busy) && t < 400) begin tick(); t++; end
    chk("final_drain", 128'(sb_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
